// File: rtl/sqrt_iterative.sv
// sqrt_iterative: iterative non-restoring integer square root.
// Resolves STEPS_PER_CYCLE root bits per clock and produces floor(sqrt(num))
// together with the non-negative remainder num - sq_root^2.
module sqrt_iterative #(
    parameter int N               = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic           clock,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   num,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N/2-1:0] sq_root,
    output logic [N/2:0]   remainder
);

    localparam int HALF = N / 2;
    localparam int RW   = HALF + 2;
    localparam int OW   = HALF + 1;
    localparam int L    = HALF / STEPS_PER_CYCLE;
    localparam int CW   = $clog2(L + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [N-1:0]    rad_q;
    logic [N-1:0]    rad_w;
    logic [HALF-1:0] root_q;
    logic [HALF-1:0] root_w;
    logic [RW-1:0]   rem_q;
    logic [RW-1:0]   rem_w;
    logic [RW-1:0]   trial;
    logic [OW-1:0]   fixed_rem;
    logic [CW-1:0]   count;
    logic            accept;
    logic            last_cycle;

    assign last_cycle = (count == CW'(L - 1));

    // State register; reset aborts any computation in flight.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    next_state = CALC;
                end
            end
            CALC: begin
                if (last_cycle) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Unrolled non-restoring steps: the remainder sign picks add or subtract
    // of {root, sign, 1}, and the inverted new sign becomes the next root bit.
    always_comb begin
        rad_w  = rad_q;
        root_w = root_q;
        rem_w  = rem_q;
        trial  = '0;
        for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
            trial = {rem_w[RW-3:0], rad_w[N-1:N-2]};
            if (rem_w[RW-1]) begin
                rem_w = trial + {root_w, 2'b11};
            end else begin
                rem_w = trial - {root_w, 2'b01};
            end
            root_w = {root_w[HALF-2:0], ~rem_w[RW-1]};
            rad_w  = {rad_w[N-3:0], 2'b00};
        end
    end

    // A negative final remainder is pulled back into 0..2*root by adding {root, 1}.
    always_comb begin
        if (rem_w[RW-1]) begin
            fixed_rem = OW'(rem_w + {1'b0, root_w, 1'b1});
        end else begin
            fixed_rem = OW'(rem_w);
        end
    end

    // Datapath registers; the result outputs only change on the last CALC edge.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rad_q     <= '0;
            root_q    <= '0;
            rem_q     <= '0;
            count     <= '0;
            sq_root   <= '0;
            remainder <= '0;
        end else if (accept) begin
            rad_q  <= num;
            root_q <= '0;
            rem_q  <= '0;
            count  <= '0;
        end else if (state == CALC) begin
            rad_q  <= rad_w;
            root_q <= root_w;
            rem_q  <= rem_w;
            count  <= count + 1'b1;
            if (last_cycle) begin
                sq_root   <= root_w;
                remainder <= fixed_rem;
            end
        end
    end

endmodule

// File: tb/tb_sqrt_iterative.sv
// tb_sqrt_iterative: directed and randomised checks of sqrt_iterative with
// one root bit per cycle (instance a) and four root bits per cycle (instance b).
module tb_sqrt_iterative;

    logic        clock;
    logic        rst_n;

    logic        a_in_valid;
    logic        a_in_ready;
    logic [31:0] a_num;
    logic        a_out_valid;
    logic        a_out_ready;
    logic [15:0] a_sq_root;
    logic [16:0] a_remainder;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [31:0] b_num;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [15:0] b_sq_root;
    logic [16:0] b_remainder;

    int errors;
    int checks;

    sqrt_iterative #(.N(32), .STEPS_PER_CYCLE(1)) dut_a (
        .clock     (clock),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .num       (a_num),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .sq_root   (a_sq_root),
        .remainder (a_remainder)
    );

    sqrt_iterative #(.N(32), .STEPS_PER_CYCLE(4)) dut_b (
        .clock     (clock),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .num       (b_num),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .sq_root   (b_sq_root),
        .remainder (b_remainder)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input bit sel, input logic valid,
                                  input logic [31:0] value, input logic ready);
        if (sel) begin
            b_in_valid  = valid;
            b_num       = value;
            b_out_ready = ready;
        end else begin
            a_in_valid  = valid;
            a_num       = value;
            a_out_ready = ready;
        end
    endtask

    function automatic logic get_in_ready(input bit sel);
        return sel ? b_in_ready : a_in_ready;
    endfunction

    function automatic logic get_out_valid(input bit sel);
        return sel ? b_out_valid : a_out_valid;
    endfunction

    function automatic logic [15:0] get_root(input bit sel);
        return sel ? b_sq_root : a_sq_root;
    endfunction

    function automatic logic [16:0] get_rem(input bit sel);
        return sel ? b_remainder : a_remainder;
    endfunction

    // Reference floor square root by greedy bit setting.
    function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
        logic [15:0] r;
        logic [15:0] c;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            c = r | (16'd1 << b);
            if (64'(c) * 64'(c) <= 64'(v)) begin
                r = c;
            end
        end
        return r;
    endfunction

    // One transaction: accept, count edges to out_valid, hold for 'stall'
    // cycles with out_ready low, then consume and confirm return to IDLE.
    task automatic run_vector(input bit sel, input logic [31:0] value, input int stall,
                              input logic [15:0] exp_root, input logic [16:0] exp_rem,
                              input int exp_lat, input string tag);
        int lat;
        int n;
        check_output({tag, "_ready"}, 64'(get_in_ready(sel)), 64'(1));
        apply_stimulus(sel, 1'b1, value, 1'b0);
        tick();
        apply_stimulus(sel, 1'b1, $urandom, 1'b0);
        check_output({tag, "_busy"}, 64'(get_in_ready(sel)), 64'(0));
        lat = 0;
        while (!get_out_valid(sel) && lat < 100) begin
            apply_stimulus(sel, 1'b1, $urandom, 1'b0);
            tick();
            lat++;
        end
        apply_stimulus(sel, 1'b0, $urandom, 1'b0);
        check_output({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        n = (stall > 0) ? stall : 1;
        for (int s = 0; s < n; s++) begin
            check_output({tag, "_root"}, 64'(get_root(sel)), 64'(exp_root));
            check_output({tag, "_rem"}, 64'(get_rem(sel)), 64'(exp_rem));
            check_output({tag, "_valid"}, 64'(get_out_valid(sel)), 64'(1));
            check_output({tag, "_noaccept"}, 64'(get_in_ready(sel)), 64'(0));
            if (s < n - 1) begin
                tick();
            end
        end
        apply_stimulus(sel, 1'b0, value, 1'b1);
        tick();
        apply_stimulus(sel, 1'b0, value, 1'b0);
        check_output({tag, "_consumed"}, 64'(get_out_valid(sel)), 64'(0));
        check_output({tag, "_idle"}, 64'(get_in_ready(sel)), 64'(1));
    endtask

    // Directed sequence followed by a randomised run against the reference.
    initial begin
        int first;
        int second;
        int lat;
        int guard;
        logic done;
        logic [15:0] root_first;
        logic [16:0] rem_first;
        logic [31:0] v;
        logic [15:0] er;

        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'd0, 1'b0);
        #3;
        check_output("rst_in_ready", 64'(a_in_ready), 64'(1));
        check_output("rst_out_valid", 64'(a_out_valid), 64'(0));
        check_output("rst_root", 64'(a_sq_root), 64'(0));
        check_output("rst_rem", 64'(a_remainder), 64'(0));
        check_output("rst_b_in_ready", 64'(b_in_ready), 64'(1));
        repeat (2) tick();
        @(negedge clock);
        rst_n = 1'b1;

        run_vector(1'b0, 32'd1000000, 0, 16'd1000, 17'd0, 16, "a_1e6");
        run_vector(1'b0, 32'hFFFFFFFF, 0, 16'hFFFF, 17'h1FFFE, 16, "a_max");
        run_vector(1'b0, 32'd0, 0, 16'd0, 17'd0, 16, "a_zero");
        run_vector(1'b0, 32'd99, 5, 16'd9, 17'd18, 16, "a_99_stall");
        run_vector(1'b1, 32'h12345678, 0, 16'h4444, 17'h02468, 4, "b_12345678");
        run_vector(1'b1, 32'hFFFFFFFF, 0, 16'hFFFF, 17'h1FFFE, 4, "b_max");
        run_vector(1'b1, 32'd2, 0, 16'd1, 17'd1, 4, "b_two");

        // Reset in the middle of a computation discards it.
        apply_stimulus(1'b0, 1'b1, 32'd5000, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b0, 32'd5000, 1'b0);
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        check_output("abort_out_valid", 64'(a_out_valid), 64'(0));
        check_output("abort_in_ready", 64'(a_in_ready), 64'(1));
        check_output("abort_root", 64'(a_sq_root), 64'(0));
        check_output("abort_rem", 64'(a_remainder), 64'(0));
        @(negedge clock);
        rst_n = 1'b1;
        run_vector(1'b0, 32'd144, 0, 16'd12, 17'd0, 16, "a_144");

        // out_ready already high before the result appears.
        apply_stimulus(1'b0, 1'b1, 32'd2, 1'b1);
        tick();
        apply_stimulus(1'b0, 1'b0, 32'd77, 1'b1);
        lat = 0;
        while (!a_out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check_output("early_lat", 64'(lat), 64'(16));
        check_output("early_root", 64'(a_sq_root), 64'(1));
        check_output("early_rem", 64'(a_remainder), 64'(1));
        tick();
        check_output("early_consumed", 64'(a_out_valid), 64'(0));
        check_output("early_idle", 64'(a_in_ready), 64'(1));

        // Back-to-back traffic: one result every 18 cycles.
        apply_stimulus(1'b0, 1'b1, 32'd50, 1'b1);
        first      = -1;
        second     = -1;
        root_first = '0;
        rem_first  = '0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (a_out_valid) begin
                if (first < 0) begin
                    first      = i;
                    root_first = a_sq_root;
                    rem_first  = a_remainder;
                end else if (second < 0) begin
                    second = i;
                end
            end
        end
        apply_stimulus(1'b0, 1'b0, 32'd50, 1'b1);
        check_output("tput_seen", 64'(first > 0 && second > 0), 64'(1));
        check_output("tput_period", 64'(second - first), 64'(18));
        check_output("tput_root", 64'(root_first), 64'(7));
        check_output("tput_rem", 64'(rem_first), 64'(1));
        guard = 0;
        while (!a_in_ready && guard < 40) begin
            tick();
            guard++;
        end
        apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0);
        check_output("tput_drain", 64'(a_in_ready), 64'(1));

        // Randomised radicands with random consumer back-pressure.
        for (int k = 0; k < 300; k++) begin
            if (k == 0) begin
                v = 32'hFFFFFFFF;
            end else if (k == 1) begin
                v = 32'd1;
            end else if (k == 2) begin
                v = 32'hFFFE0001;
            end else begin
                v = $urandom;
            end
            er = ref_sqrt(v);
            apply_stimulus(1'b0, 1'b1, v, 1'($urandom_range(0, 1)));
            tick();
            lat = 0;
            while (!a_out_valid && lat < 100) begin
                apply_stimulus(1'b0, 1'b0, $urandom, 1'($urandom_range(0, 1)));
                tick();
                lat++;
            end
            check_output("rnd_lat", 64'(lat), 64'(16));
            check_output("rnd_root", 64'(a_sq_root), 64'(er));
            check_output("rnd_rem", 64'(a_remainder), 64'(v) - 64'(er) * 64'(er));
            check_output("rnd_identity", 64'(a_sq_root) * 64'(a_sq_root) + 64'(a_remainder),
                         64'(v));
            check_output("rnd_rem_bound", 64'(64'(a_remainder) <= 64'(a_sq_root) * 2), 64'(1));
            done  = 1'b0;
            guard = 0;
            while (!done && guard < 50) begin
                done = 1'($urandom_range(0, 1));
                apply_stimulus(1'b0, 1'b0, $urandom, done);
                tick();
                guard++;
            end
            apply_stimulus(1'b0, 1'b0, 32'd0, 1'b0);
            check_output("rnd_idle", 64'(a_in_ready), 64'(1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
